bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential decoder converting a multi-digit packed BCD value (as produced by
//  the reaction-time BCD counter, BCD0 = least significant) into unsigned binary.
//  Feeds binary-domain consumers (best-time compare, averaging, UART report).
//  Start/busy/done handshake; fixed latency; flags any digit > 9.
// PARAMETERS
//  NDIGITS  3   number of BCD digits converted (>= 1)
//  BIN_W    10  binary output width; must satisfy 10^NDIGITS - 1 < 2^BIN_W
// PORTS
//  Clock       in   1          rising-edge clock
//  Clear       in   1          synchronous reset, active-high
//  start       in   1          request conversion; sampled only in IDLE
//  bcd_in      in   4*NDIGITS  packed digits, [3:0] = BCD0 (ones), MS digit at top
//  busy        out  1          high while in CONVERT
//  done        out  1          one-cycle pulse: bin_out/error valid and updated
//  bin_out     out  BIN_W      result of last completed conversion, held until next
//  error       out  1          last conversion contained a digit > 9; held like bin_out
// BEHAVIOUR
//  - Reset (Clear=1 at an edge): state=IDLE, busy=0, done=0, bin_out=0, error=0,
//    internal acc/index/capture cleared. Clear has priority over start and over
//    any conversion in flight; an aborted conversion produces no done pulse.
//  - States: IDLE, CONVERT.
//    IDLE: start=1 at edge E0 -> capture bcd_in into internal register, acc=0,
//      err_acc=0, idx=NDIGITS-1, state=CONVERT. bcd_in is don't-care after E0.
//    CONVERT: each edge: acc <= acc*10 + digit[idx] (acc*10 = (acc<<3)+(acc<<1),
//      computed at BIN_W+4 bits, truncated to BIN_W); err_acc |= (digit[idx] > 9);
//      idx decrements. Digits processed MS first.
//      At edge E_NDIGITS (last digit): state=IDLE, done<=1, error<=err_acc|this,
//      bin_out <= (error ? 0 : final acc).
//  - Latency: start sampled at E0 -> done high in the cycle after E_NDIGITS
//    (NDIGITS+1 edges total); fixed, independent of digit values or error.
//  - busy=1 in cycles after E0 through E_NDIGITS; 0 in the done cycle.
//  - done is a single-cycle pulse; deasserts at the next edge unless a new
//    conversion completes there (impossible for NDIGITS >= 1).
//  - start while busy is ignored (no queueing). start in the done cycle is
//    accepted (state already IDLE): back-to-back throughput = 1 per NDIGITS+1.
//  - Invalid digits (A-F): conversion still runs full length; bin_out=0, error=1.
//  - bin_out/error only change at the done edge or Clear; stable otherwise.
//  - Max output for defaults: 999 = 10'h3E7; no overflow possible when
//    BIN_W satisfies the parameter rule.
// TESTING
//  1. Clear=1 one edge -> busy=0, done=0, bin_out=0, error=0.
//  2. bcd_in=12'h999, start 1 cycle -> busy 3 cycles, done in cycle 4, bin_out=999.
//  3. bcd_in=12'h407 then 12'h000 back-to-back (start in done cycle) -> 407, then 0;
//     two done pulses exactly 4 cycles apart.
//  4. bcd_in=12'h3A5 -> done after 4 cycles, error=1, bin_out=0; next 12'h012 -> 12, error=0.
//  5. start pulsed during CONVERT with different bcd_in -> ignored; result from first capture.
//  6. Clear asserted at 2nd CONVERT edge -> no done pulse, outputs 0, next start converts normally.

Source files
------------

// File: rtl/bcd_to_binary_if.sv
// Handshake bundle for the BCD-to-binary decoder: start/bcd_in in, busy/done/result out.
interface bcd_to_binary_if #(
   parameter int unsigned NDIGITS = 3,
   parameter int unsigned BIN_W   = 10
);
   logic                   start;
   logic [4*NDIGITS-1:0]   bcd_in;
   logic                   busy;
   logic                   done;
   logic [BIN_W-1:0]       bin_out;
   logic                   error;

   modport master (
      output start, bcd_in,
      input  busy, done, bin_out, error
   );

   modport slave (
      input  start, bcd_in,
      output busy, done, bin_out, error
   );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary decoder, one digit per clock, most significant digit first.
// Fixed latency of NDIGITS+1 edges from start to done; any digit above 9 forces result 0.
module bcd_to_binary #(
   parameter int unsigned NDIGITS = 3,
   parameter int unsigned BIN_W   = 10
) (
   input  logic            Clock,
   input  logic            Clear,
   bcd_to_binary_if.slave  bus
);
   localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   typedef enum logic {StIdle, StConvert} state_e;

   state_e               state_q, state_d;
   logic [4*NDIGITS-1:0] cap_q, cap_d;
   logic [BIN_W-1:0]     acc_q, acc_d;
   logic                 err_acc_q, err_acc_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic                 done_q, done_d;
   logic [BIN_W-1:0]     bin_q, bin_d;
   logic                 error_q, error_d;

   logic [3:0]           digit;
   logic                 digit_bad;
   logic [BIN_W-1:0]     acc_next;

   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_q == IdxW'(i)) digit = cap_q[4*i +: 4];
      end
   end

   // acc*10 as two shifts; truncation to BIN_W is harmless when BIN_W fits 10^NDIGITS-1
   assign digit_bad = (digit > 4'd9);
   assign acc_next  = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

   always_comb begin
      state_d   = state_q;
      cap_d     = cap_q;
      acc_d     = acc_q;
      err_acc_d = err_acc_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      bin_d     = bin_q;
      error_d   = error_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               cap_d     = bus.bcd_in;
               acc_d     = '0;
               err_acc_d = 1'b0;
               idx_d     = IdxW'(NDIGITS - 1);
               state_d   = StConvert;
            end
         end
         StConvert: begin
            acc_d     = acc_next;
            err_acc_d = err_acc_q | digit_bad;
            idx_d     = idx_q - IdxW'(1);
            if (idx_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
               error_d = err_acc_q | digit_bad;
               bin_d   = (err_acc_q | digit_bad) ? '0 : acc_next;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= StIdle;
         cap_q     <= '0;
         acc_q     <= '0;
         err_acc_q <= 1'b0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         bin_q     <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cap_q     <= cap_d;
         acc_q     <= acc_d;
         err_acc_q <= err_acc_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         bin_q     <= bin_d;
         error_q   <= error_d;
      end
   end

   assign bus.busy    = (state_q == StConvert);
   assign bus.done    = done_q;
   assign bus.bin_out = bin_q;
   assign bus.error   = error_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomised bench for bcd_to_binary: decimal reference model plus directed literal scenarios.
module tb_bcd_to_binary;
   localparam int unsigned ND = 3;
   localparam int unsigned BW = 10;

   logic Clock = 1'b0;
   logic Clear;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   bcd_to_binary_if #(.NDIGITS(ND), .BIN_W(BW)) bus ();

   bcd_to_binary #(.NDIGITS(ND), .BIN_W(BW)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal meaning of the packed digits: sum of digit * 10^position, zero if any digit > 9.
   function automatic void ref_conv(input logic [4*ND-1:0] v, output int val, output bit err);
      int d;
      val = 0;
      err = 1'b0;
      for (int i = 0; i < ND; i++) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) err = 1'b1;
         val += d * (10 ** i);
      end
      if (err) val = 0;
   endfunction

   function automatic logic [4*ND-1:0] rand_bcd();
      logic [4*ND-1:0] v;
      for (int i = 0; i < ND; i++) begin
         if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
         else v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   // Model: a conversion accepted while idle completes ND edges later.
   int rem = 0;
   int pend_val = 0;
   bit pend_err = 1'b0;
   bit m_done = 1'b0;
   int m_bin = 0;
   bit m_err = 1'b0;

   always @(posedge Clock) begin
      bit was_idle;
      if (Clear) begin
         rem    = 0;
         m_done = 1'b0;
         m_bin  = 0;
         m_err  = 1'b0;
      end else begin
         was_idle = (rem == 0);
         m_done   = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_done = 1'b1;
               m_bin  = pend_val;
               m_err  = pend_err;
            end
         end
         if (was_idle && bus.start) begin
            ref_conv(bus.bcd_in, pend_val, pend_err);
            rem = ND;
         end
      end
   end

   always @(negedge Clock) begin
      if (chk_en) begin
         check("done", 32'(bus.done), 32'(m_done));
         check("busy", 32'(bus.busy), 32'(rem > 0));
         check("bin_out", 32'(bus.bin_out), 32'(m_bin));
         check("error", 32'(bus.error), 32'(m_err));
      end
   end

   // Called at a negedge while idle; returns at the negedge of the done cycle.
   task automatic run(input logic [4*ND-1:0] v, input int exp_bin, input bit exp_err,
                      input bit glitch, input logic [4*ND-1:0] gv, input string name);
      int n;
      bit got;
      bus.start  = 1'b1;
      bus.bcd_in = v;
      @(posedge Clock);
      #1;
      bus.start  = 1'b0;
      bus.bcd_in = rand_bcd();
      n   = 0;
      got = 1'b0;
      while (!got && n < 12) begin
         @(negedge Clock);
         n++;
         if (glitch && n == 1) begin
            bus.start  = 1'b1;
            bus.bcd_in = gv;
         end else if (glitch && n == 2) begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) got = 1'b1;
      end
      check({name, "_seen"}, 32'(got), 32'd1);
      check({name, "_latency"}, 32'(n), 32'(ND + 1));
      check({name, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
      check({name, "_err"}, 32'(bus.error), 32'(exp_err));
   endtask

   initial begin
      int  saw;
      Clear      = 1'b1;
      bus.start  = 1'b0;
      bus.bcd_in = '0;
      repeat (2) @(posedge Clock);
      #1;
      Clear  = 1'b0;
      chk_en = 1'b1;
      @(negedge Clock);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bin", 32'(bus.bin_out), 32'd0);
      check("rst_err", 32'(bus.error), 32'd0);

      run(12'h999, 999, 1'b0, 1'b0, '0, "max");
      @(negedge Clock);
      run(12'h407, 407, 1'b0, 1'b0, '0, "b2b_a");
      run(12'h000, 0, 1'b0, 1'b0, '0, "b2b_b");
      @(negedge Clock);
      run(12'h3A5, 0, 1'b1, 1'b0, '0, "bad_digit");
      @(negedge Clock);
      run(12'h012, 12, 1'b0, 1'b0, '0, "after_bad");
      @(negedge Clock);
      run(12'h258, 258, 1'b0, 1'b1, 12'h777, "start_busy");

      // Clear at the second conversion edge aborts without a done pulse.
      @(negedge Clock);
      bus.start  = 1'b1;
      bus.bcd_in = 12'h555;
      @(posedge Clock);
      #1;
      bus.start = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
      Clear = 1'b0;
      saw = 0;
      repeat (6) begin
         @(negedge Clock);
         if (bus.done === 1'b1) saw = 1;
      end
      check("abort_no_done", 32'(saw), 32'd0);
      check("abort_bin", 32'(bus.bin_out), 32'd0);
      check("abort_err", 32'(bus.error), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      run(12'h086, 86, 1'b0, 1'b0, '0, "post_abort");

      for (int c = 0; c < 3000; c++) begin
         @(negedge Clock);
         bus.start  = ($urandom_range(0, 2) == 0);
         bus.bcd_in = rand_bcd();
         Clear      = ($urandom_range(0, 199) == 0);
      end
      @(negedge Clock);
      bus.start = 1'b0;
      Clear     = 1'b0;
      repeat (8) @(negedge Clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
